// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
package pwm_pkg;

    // Default counter width and stuck timeout, reused by generator and benches
    localparam int PWM_CNT_W   = 8;
    localparam int PWM_TIMEOUT = 200;

    // Capture FSM states
    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEASURE   = 2'd1,
        STUCK     = 2'd2
    } cap_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Three-flop input synchronizer for the PWM signal with rising-edge detect.
// level is the second synchronizer stage; rise is a one-cycle pulse on a
// 0->1 transition of level.
module pwm_in_sync
    import pwm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Shift the asynchronous input through three flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign level = r_s2;
    assign rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with stuck-signal detection.
// Each complete cycle (rise to rise) is reported on period_cnt/high_cnt with
// a one-cycle meas_valid strobe. No rise for TIMEOUT cycles flags the input
// as stuck high or low according to its current level.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = PWM_CNT_W,
    parameter int TIMEOUT = PWM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic             w_level;
    logic             w_rise;

    cap_state_t       r_state;
    cap_state_t       w_state_nxt;

    logic [CNT_W-1:0] r_per_ctr;
    logic [CNT_W-1:0] r_hi_ctr;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_stk_hi;
    logic             r_stk_lo;

    logic [CNT_W-1:0] w_per_nxt;
    logic [CNT_W-1:0] w_hi_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic [CNT_W-1:0] w_high_nxt;
    logic             w_valid_nxt;
    logic             w_stk_hi_nxt;
    logic             w_stk_lo_nxt;

    pwm_in_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .level  (w_level),
        .rise   (w_rise)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= WAIT_RISE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, counter updates and result/flag next values
    always_comb begin
        w_state_nxt  = r_state;
        w_per_nxt    = r_per_ctr;
        w_hi_nxt     = r_hi_ctr;
        w_period_nxt = r_period;
        w_high_nxt   = r_high;
        w_valid_nxt  = 1'b0;
        w_stk_hi_nxt = 1'b0;
        w_stk_lo_nxt = 1'b0;

        case (r_state)
            WAIT_RISE: begin
                // The partial period before the first rise is discarded
                if (w_rise) begin
                    w_per_nxt   = ONE;
                    w_hi_nxt    = ONE;
                    w_state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                // A rise on the timeout cycle still counts as a measurement
                if (w_rise) begin
                    w_period_nxt = r_per_ctr;
                    w_high_nxt   = r_hi_ctr;
                    w_valid_nxt  = 1'b1;
                    w_per_nxt    = ONE;
                    w_hi_nxt     = ONE;
                end else if (r_per_ctr == TO_CNT) begin
                    w_state_nxt  = STUCK;
                    w_stk_hi_nxt = w_level;
                    w_stk_lo_nxt = ~w_level;
                end else begin
                    w_per_nxt = r_per_ctr + ONE;
                    w_hi_nxt  = r_hi_ctr + {{(CNT_W-1){1'b0}}, w_level};
                end
            end
            STUCK: begin
                // Flags track the level until a rise restarts measurement
                if (w_rise) begin
                    w_per_nxt   = ONE;
                    w_hi_nxt    = ONE;
                    w_state_nxt = MEASURE;
                end else begin
                    w_stk_hi_nxt = w_level;
                    w_stk_lo_nxt = ~w_level;
                end
            end
            default: begin
                w_state_nxt = WAIT_RISE;
            end
        endcase
    end

    // Counter, result and flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_per_ctr <= '0;
            r_hi_ctr  <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_stk_hi  <= 1'b0;
            r_stk_lo  <= 1'b0;
        end else begin
            r_per_ctr <= w_per_nxt;
            r_hi_ctr  <= w_hi_nxt;
            r_period  <= w_period_nxt;
            r_high    <= w_high_nxt;
            r_valid   <= w_valid_nxt;
            r_stk_hi  <= w_stk_hi_nxt;
            r_stk_lo  <= w_stk_lo_nxt;
        end
    end

    assign period_cnt = r_period;
    assign high_cnt   = r_high;
    assign meas_valid = r_valid;
    assign stuck_high = r_stk_hi;
    assign stuck_low  = r_stk_lo;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed waveforms with literal expectations plus
// randomized segments, all compared every cycle against a rise-timestamp model.
module tb_pwm_capture;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             meas_valid;
    logic             stuck_high;
    logic             stuck_low;

    always #5 clk = ~clk;

    pwm_capture #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .period_cnt (period_cnt),
        .high_cnt   (high_cnt),
        .meas_valid (meas_valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Observed-result bookkeeping used by the literal checks
    int n_valid  = 0;
    int last_per = 0;
    int last_hi  = 0;

    // Reference model: input samples, rise timestamps and a running high sum
    bit samp [0:3];
    int mode;        // 0 waiting for first rise, 1 measuring, 2 stuck
    int cyc;
    int last_rise;
    int high_sum;
    int e_per, e_hi;
    bit e_v, e_sh, e_sl;
    bit armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model update and per-cycle comparison, 1 time unit after each edge
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) samp[i] = 1'b0;
            mode = 0; cyc = 0; last_rise = 0; high_sum = 0;
            e_per = 0; e_hi = 0; e_v = 0; e_sh = 0; e_sl = 0;
            armed = 1'b1;
        end else begin
            // samp[2] is the measured level of the cycle just acted on, samp[3] the one before
            samp[3] = samp[2]; samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = pwm_in;
            cyc++;
            e_v = 1'b0;
            if (samp[2] && !samp[3]) begin
                if (mode == 1) begin
                    e_v   = 1'b1;
                    e_per = cyc - last_rise;
                    e_hi  = high_sum;
                end
                mode = 1; last_rise = cyc; high_sum = 0;
                e_sh = 1'b0; e_sl = 1'b0;
            end else if (mode == 1 && (cyc - last_rise) == TIMEOUT) begin
                mode = 2;
            end
            if (mode == 2) begin
                e_sh = samp[2];
                e_sl = !samp[2];
            end
            high_sum += int'(samp[2]);
        end
        if (armed) begin
            n_total++;
            if (period_cnt === CNT_W'(e_per) && high_cnt === CNT_W'(e_hi) &&
                meas_valid === e_v && stuck_high === e_sh && stuck_low === e_sl) begin
                n_pass++;
            end else begin
                $display("FAIL model t=%0t: got per=%0d hi=%0d v=%b sh=%b sl=%b, expected per=%0d hi=%0d v=%b sh=%b sl=%b",
                         $time, period_cnt, high_cnt, meas_valid, stuck_high, stuck_low,
                         e_per, e_hi, e_v, e_sh, e_sl);
            end
            if (meas_valid === 1'b1) begin
                n_valid++;
                last_per = int'(period_cnt);
                last_hi  = int'(high_cnt);
            end
        end
    end

    task automatic run_wave(input int per, input int hi, input int n);
        int ph;
        ph = 0;
        repeat (n) begin
            @(negedge clk);
            pwm_in = (ph < hi);
            ph = (ph + 1) % per;
        end
    endtask

    task automatic run_const(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            pwm_in = v;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_per"}, period_cnt, 0);
        check({tag, "_hi"},  high_cnt, 0);
        check({tag, "_v"},   meas_valid, 0);
        check({tag, "_sh"},  stuck_high, 0);
        check({tag, "_sl"},  stuck_low, 0);
    endtask

    initial begin
        int kind, per, hi;

        // Reset state
        rst_n = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // 50 % duty, period 10: first rise discarded, nine full periods reported
        n_valid = 0;
        run_wave(10, 5, 100);
        check("p50_count", n_valid, 9);
        check("p50_per", last_per, 10);
        check("p50_hi", last_hi, 5);

        // Duty step 5 -> 6
        n_valid = 0;
        run_wave(10, 6, 100);
        check("step_count", n_valid, 10);
        check("step_per", last_per, 10);
        check("step_hi", last_hi, 6);

        // Held low: stuck_low, results hold
        n_valid = 0;
        run_const(1'b0, 40);
        check("low_count", n_valid, 0);
        check("low_sl", stuck_low, 1);
        check("low_sh", stuck_high, 0);
        check("low_per", period_cnt, 10);
        check("low_hi", high_cnt, 6);

        // Held high: stuck_high
        n_valid = 0;
        run_const(1'b1, 40);
        check("high_count", n_valid, 0);
        check("high_sh", stuck_high, 1);
        check("high_sl", stuck_low, 0);

        // Resume at 30 %: recovery rise is not reported, then 10/3
        n_valid = 0;
        run_wave(10, 3, 50);
        check("r30_count", n_valid, 3);
        check("r30_per", last_per, 10);
        check("r30_hi", last_hi, 3);
        check("r30_sh", stuck_high, 0);
        check("r30_sl", stuck_low, 0);

        // Minimum period
        run_wave(2, 1, 40);
        check("alt_per", last_per, 2);
        check("alt_hi", last_hi, 1);

        // Period equal to TIMEOUT is a valid measurement, never stuck
        run_wave(TIMEOUT, 7, 100);
        check("pto_per", last_per, TIMEOUT);
        check("pto_hi", last_hi, 7);
        check("pto_sh", stuck_high, 0);
        check("pto_sl", stuck_low, 0);

        // One-cycle reset mid-period
        run_wave(10, 4, 15);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        rst_n = 1'b1;
        n_valid = 0;
        run_wave(10, 4, 12);
        check("midrst_count", n_valid, 0);
        run_wave(10, 4, 30);
        check("midrst_per", last_per, 10);
        check("midrst_hi", last_hi, 4);

        // Randomized segments checked by the model only
        for (int s = 0; s < 60; s++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else if (kind == 1) begin
                repeat ($urandom_range(10, 40)) begin
                    @(negedge clk);
                    pwm_in = 1'($urandom_range(0, 1));
                end
            end else begin
                per = $urandom_range(2, 30);
                hi  = $urandom_range(0, per);
                run_wave(per, hi, $urandom_range(20, 120));
            end
        end

        run_const(1'b0, 5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measurement stage directly downstream of the PWM generator. It samples the PWM output, measures the period and high time of every complete cycle in clock counts, and reports each result with a one-cycle valid strobe. It flags a constant (0 % or 100 % duty) signal as stuck after a programmable timeout. Used for closed-loop self-check of duty steps and as a bench monitor.

## Interface
- CNT_W, 8, width of the period/high counters and outputs
- TIMEOUT, 200, cycles without a rising edge before stuck is declared; legal range 2 ≤ TIMEOUT ≤ 2^CNT_W−1
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  reset; one clock, synchronous, active-low
- pwm_in  in  1  PWM signal under measurement (may be asynchronous)
- period_cnt  out  CNT_W  clocks between last two rising edges
- high_cnt  out  CNT_W  clocks pwm_in was high within that period
- meas_valid  out  1  one-cycle strobe: period_cnt/high_cnt just updated
- stuck_high  out  1  no rising edge for TIMEOUT clocks, input high
- stuck_low  out  1  no rising edge for TIMEOUT clocks, input low

## Operation
- Input path: s1 <= pwm_in, s2 <= s1, s3 <= s2; rise = s2 & ~s3. All measurement uses s2.
- Internal counters per_ctr, hi_ctr (CNT_W bits).
- States: WAIT_RISE (after reset), MEASURE, STUCK.
- WAIT_RISE: counters idle; the first partial period is discarded. On rise: per_ctr <= 1, hi_ctr <= 1, go MEASURE. No meas_valid.
- MEASURE, no rise: per_ctr <= per_ctr+1; hi_ctr <= hi_ctr+s2.
- MEASURE, rise: period_cnt <= per_ctr, high_cnt <= hi_ctr, meas_valid <= 1, per_ctr <= 1, hi_ctr <= 1.
- MEASURE, per_ctr == TIMEOUT and no rise: go STUCK. period_cnt/high_cnt hold last values. No meas_valid.
- STUCK: stuck_high = s2, stuck_low = ~s2 (registered, follow level each cycle). On rise: clear both flags, per_ctr <= 1, hi_ctr <= 1, go MEASURE. The first period after recovery is reported normally.
- Rise and timeout in the same cycle: rise wins (normal measurement).
- TIMEOUT legal range guarantees the counters never wrap. No saturation logic.
- Minimum measurable period 2 (alternating high/low): period_cnt=2, high_cnt=1.
- Reset values: period_cnt=0, high_cnt=0, meas_valid=0, stuck_high=0, stuck_low=0, s1..s3=0, counters=0, state WAIT_RISE.
- Reset mid-measurement discards the partial period. The next result needs two rises after reset deasserts.

## Timing
- pwm_in first sampled high at edge k → rise visible during cycle after k+1 → meas_valid high for exactly the one cycle after edge k+2 (3-edge latency).
- period_cnt/high_cnt change only in the cycle meas_valid is high, stable otherwise.
- Stuck flags assert TIMEOUT cycles after the last rise (+1 for the state register). They deassert at the same edge that moves to MEASURE.
- meas_valid and stuck flags are never high in the same cycle.

## Structure
- Shared package pwm_pkg:
  - state enum {WAIT_RISE, MEASURE, STUCK}
  - default CNT_W and TIMEOUT constants, shared with the generator for bench reuse
- Sub-module pwm_in_sync: the 3-flop synchronizer plus rise output (clk, rst_n, pwm_in → level, rise).
- The top level holds the FSM, counters and output registers.

## Test plan
- Generator at 50 % (period 10): first meas_valid after the second rise. Thereafter every 10 cycles period_cnt=10, high_cnt=5.
- Step duty 5→6 mid-run: the period in progress reports high_cnt=5 or 6. From the next full period, period_cnt=10, high_cnt=6 steady.
- Input held low (0 % duty) from MEASURE: no meas_valid. stuck_low=1 TIMEOUT+1 cycles after the last rise, stuck_high=0, outputs hold last values.
- Input held high (100 %): stuck_high=1. Then resume a 30 % waveform: flags clear on the first rise, next valid reports period 10, high 3.
- Alternating 1/0 every cycle: period_cnt=2, high_cnt=1 every 2 cycles. Rise coincident with per_ctr==TIMEOUT (period = TIMEOUT) gives a valid measurement, not stuck.
- Assert rst_n=0 for one cycle mid-period: all outputs 0 next cycle. No meas_valid until two rises later.
